// File: rtl/spram_image_tx_pkg.sv
// Shared definitions for the SPRAM image readback path: FSM encoding, frame size
// derivation and the 12-bit pixel byte format shared with the RX unpacker.
package spram_image_tx_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_SEND_HI = 3'd3;
  localparam logic [2:0] ST_SEND_LO = 3'd4;
  localparam logic [2:0] ST_FIN     = 3'd5;

  // Pixel wire format: {HI_PAD, pix[11:8]} first, then pix[7:0].
  localparam logic [3:0] HI_PAD      = 4'h0;
  localparam logic       PHASE_HI    = 1'b0;
  localparam logic       PHASE_LO    = 1'b1;
  localparam logic       PHASE_FIRST = PHASE_HI;

  localparam int unsigned PIX_MAX = 65536;

  function automatic int unsigned pix_total(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/spram_image_tx_if.sv
// SPRAM port and UART TX byte stream as seen by the image readback block.
interface spram_image_tx_if;
  logic        spram_req;
  logic        spram_gnt;
  logic [15:0] spram_addr;
  logic        spram_ce;
  logic        spram_wre;
  logic [11:0] spram_rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output spram_req, spram_addr, spram_ce, spram_wre, tx_data, tx_valid,
    input  spram_gnt, spram_rd_data, tx_ready
  );

  modport slave (
    input  spram_req, spram_addr, spram_ce, spram_wre, tx_data, tx_valid,
    output spram_gnt, spram_rd_data, tx_ready
  );
endinterface

// File: rtl/spram_image_tx_pix_byte_serializer.sv
// Holds one 12-bit pixel and emits it as two bytes (hi then lo) over valid/ready.
module pix_byte_serializer
  import spram_image_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] pix,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        last_byte_accepted
);

  logic [11:0] pix_q, pix_d;
  logic        valid_q, valid_d;
  logic        phase_q, phase_d;
  logic        fire;

  always_comb begin
    pix_d   = pix_q;
    valid_d = valid_q;
    phase_d = phase_q;
    fire    = valid_q && tx_ready;
    // A load is only accepted between pixels so tx_data never changes under valid.
    if (load && !valid_q) begin
      pix_d   = pix;
      valid_d = 1'b1;
      phase_d = PHASE_FIRST;
    end else if (fire) begin
      if (phase_q == PHASE_HI) begin
        phase_d = PHASE_LO;
      end else begin
        valid_d = 1'b0;
        phase_d = PHASE_FIRST;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_q   <= '0;
      valid_q <= 1'b0;
      phase_q <= PHASE_FIRST;
    end else begin
      pix_q   <= pix_d;
      valid_q <= valid_d;
      phase_q <= phase_d;
    end
  end

  assign tx_data            = (phase_q == PHASE_HI) ? {HI_PAD, pix_q[11:8]} : pix_q[7:0];
  assign tx_valid           = valid_q;
  assign last_byte_accepted = fire && (phase_q == PHASE_LO);

endmodule

// File: rtl/spram_image_tx.sv
// Image readback: on start, reads pixels 0..W*H-1 from the shared SPRAM port and
// streams each as two bytes to the UART TX; supports abort and grant loss.
module spram_image_tx
  import spram_image_tx_pkg::*;
#(
  parameter int unsigned W      = 200,
  parameter int unsigned H      = 185,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  spram_image_tx_if.master bus,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pix_cnt
);

  localparam int unsigned PIX_TOTAL = pix_total(W, H);
  localparam logic [15:0] LAST_PIX  = 16'(PIX_TOTAL - 1);
  localparam logic [1:0]  LAT_END   = 2'(RD_LAT);

  if (PIX_TOTAL == 0 || PIX_TOTAL > PIX_MAX) begin : g_bad_size
    $error("spram_image_tx: W*H must be in 1..65536");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
    $error("spram_image_tx: RD_LAT must be in 1..3");
  end

  logic [2:0]  state_q, state_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        ce_q, ce_d;
  logic        busy_q, busy_d;
  logic        abort_q, abort_d;
  logic [1:0]  lat_q, lat_d;
  logic        ser_load;
  logic        ser_valid;
  logic        ser_last;
  logic [7:0]  ser_data;
  logic        abort_pend;

  assign abort_pend = abort_q || abort;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    addr_d    = addr_q;
    ce_d      = ce_q;
    busy_d    = busy_q;
    abort_d   = abort_q;
    lat_d     = lat_q;
    ser_load  = 1'b0;
    if (state_q != ST_IDLE && abort) abort_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_REQ;
          busy_d    = 1'b1;
          pix_cnt_d = '0;
          abort_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (abort_pend) begin
          state_d = ST_FIN;
        end else if (bus.spram_gnt) begin
          addr_d  = pix_cnt_q;
          ce_d    = 1'b1;
          lat_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Grant loss beats a same-cycle capture: a read is only trusted if the grant held throughout.
        if (!bus.spram_gnt) begin
          ce_d    = 1'b0;
          state_d = ST_REQ;
        end else if (lat_q == LAT_END) begin
          ser_load = 1'b1;
          ce_d     = 1'b0;
          state_d  = ST_SEND_HI;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      ST_SEND_HI: begin
        if (ser_valid && bus.tx_ready) state_d = ST_SEND_LO;
      end
      ST_SEND_LO: begin
        if (ser_last) begin
          if (abort_pend || pix_cnt_q == LAST_PIX) begin
            state_d = ST_FIN;
          end else begin
            pix_cnt_d = pix_cnt_q + 16'd1;
            state_d   = ST_REQ;
          end
        end
      end
      ST_FIN: begin
        busy_d    = 1'b0;
        pix_cnt_d = '0;
        abort_d   = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pix_cnt_q <= '0;
      addr_q    <= '0;
      ce_q      <= 1'b0;
      busy_q    <= 1'b0;
      abort_q   <= 1'b0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      addr_q    <= addr_d;
      ce_q      <= ce_d;
      busy_q    <= busy_d;
      abort_q   <= abort_d;
      lat_q     <= lat_d;
    end
  end

  pix_byte_serializer u_ser (
    .clk                (clk),
    .rst_n              (rst_n),
    .load               (ser_load),
    .pix                (bus.spram_rd_data),
    .tx_data            (ser_data),
    .tx_valid           (ser_valid),
    .tx_ready           (bus.tx_ready),
    .last_byte_accepted (ser_last)
  );

  assign bus.spram_req  = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign bus.spram_addr = addr_q;
  assign bus.spram_ce   = ce_q;
  assign bus.spram_wre  = 1'b0;
  assign bus.tx_data    = ser_data;
  assign bus.tx_valid   = ser_valid;
  assign busy           = busy_q;
  assign done           = (state_q == ST_FIN);
  assign pix_cnt        = pix_cnt_q;

endmodule
